// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing and helpers for the long-latency write hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned MAX_PENDING = 4;
  localparam int unsigned CNT_WIDTH   = 32;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned PEND_W      = 3;

  typedef logic [IDX_W-1:0] reg_idx_t;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side issue/writeback bundle and scoreboard status outputs.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic                 issue_valid;
  logic                 issue_long;
  reg_idx_t             issue_rd;
  reg_idx_t             rs1_index;
  reg_idx_t             rs2_index;
  logic                 rs1_used;
  logic                 rs2_used;
  logic                 flush;
  logic                 wb_valid;
  reg_idx_t             wb_rd;
  logic                 stall;
  logic [NUM_REGS-1:0]  busy_vector;
  logic [PEND_W-1:0]    pending_count;
  logic [CNT_WIDTH-1:0] stall_count;

  modport master (
    output issue_valid, issue_long, issue_rd, rs1_index, rs2_index,
           rs1_used, rs2_used, flush, wb_valid, wb_rd,
    input  stall, busy_vector, pending_count, stall_count
  );

  modport slave (
    input  issue_valid, issue_long, issue_rd, rs1_index, rs2_index,
           rs1_used, rs2_used, flush, wb_valid, wb_rd,
    output stall, busy_vector, pending_count, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Busy-bit scoreboard for long-latency writes; stalls issue on RAW/WAW hazards
// or when all pending slots are in use. Same-cycle writebacks are forwarded.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  wb_mask_c;
  logic [NUM_REGS-1:0]  eff_busy_c;
  logic [PEND_W-1:0]    pending_q;
  logic [PEND_W-1:0]    pending_after_wb_c;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic                 raw_c;
  logic                 waw_c;
  logic                 full_c;
  logic                 stall_c;
  logic                 accept_c;
  logic                 set_event_c;
  logic                 clear_event_c;

  // Hazard evaluation against busy bits with the current writeback removed
  always_comb begin
    wb_mask_c          = sb.wb_valid ? idx_onehot(sb.wb_rd) : '0;
    eff_busy_c         = busy_q & ~wb_mask_c;
    raw_c              = (sb.rs1_used & eff_busy_c[sb.rs1_index]) |
                         (sb.rs2_used & eff_busy_c[sb.rs2_index]);
    waw_c              = sb.issue_long & eff_busy_c[sb.issue_rd];
    pending_after_wb_c = pending_q - PEND_W'(sb.wb_valid);
    // x0 writes take no slot, so they can never be held back for capacity
    full_c             = sb.issue_long & (sb.issue_rd != '0) &
                         (pending_after_wb_c == PEND_W'(MAX_PENDING));
    stall_c            = sb.issue_valid & ~sb.flush & (raw_c | waw_c | full_c);
    accept_c           = sb.issue_valid & ~sb.flush & ~stall_c;
    set_event_c        = accept_c & sb.issue_long & (sb.issue_rd != '0);
    clear_event_c      = sb.wb_valid & busy_q[sb.wb_rd];
  end

  assign busy_q[0] = 1'b0;

  // One busy cell per tracked register; a set beats a same-cycle clear
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
    logic cell_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cell_q <= 1'b0;
      end else if (set_event_c && (sb.issue_rd == IDX_W'(i))) begin
        cell_q <= 1'b1;
      end else if (sb.wb_valid && (sb.wb_rd == IDX_W'(i))) begin
        cell_q <= 1'b0;
      end
    end

    assign busy_q[i] = cell_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_q + PEND_W'(set_event_c) - PEND_W'(clear_event_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign sb.stall         = stall_c;
  assign sb.busy_vector   = busy_q;
  assign sb.pending_count = pending_q;
  assign sb.stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations queued at drive time,
// popped and asserted when the corresponding output is sampled.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_sc = 0;
  int   stray = 0;

  hazard_scoreboard_if hz ();

  hazard_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (hz)
  );

  always #5 clk = ~clk;

  // Writebacks that hit a non-busy register (including x0)
  always @(posedge clk) begin
    if (!reset && hz.wb_valid && !hz.busy_vector[hz.wb_rd]) stray++;
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL queue_empty observed=%0h expected=queued_value", obs);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic iv, input logic il, input reg_idx_t rd,
                       input reg_idx_t r1, input reg_idx_t r2,
                       input logic u1, input logic u2, input logic fl,
                       input logic wv, input reg_idx_t wr);
    hz.issue_valid = iv;
    hz.issue_long  = il;
    hz.issue_rd    = rd;
    hz.rs1_index   = r1;
    hz.rs2_index   = r2;
    hz.rs1_used    = u1;
    hz.rs2_used    = u2;
    hz.flush       = fl;
    hz.wb_valid    = wv;
    hz.wb_rd       = wr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check combinational stall for the driven inputs, then clock once
  task automatic step(input string tag, input logic exp_stall);
    expect_val({tag, "_stall"}, 32'(exp_stall));
    #3;
    check(32'(hz.stall));
    if (exp_stall) exp_sc++;
    cyc();
  endtask

  task automatic regs(input string tag, input logic [31:0] busy, input int pend);
    expect_val({tag, "_busy"}, busy);
    expect_val({tag, "_pending"}, 32'(pend));
    expect_val({tag, "_stall_count"}, 32'(exp_sc));
    check(hz.busy_vector);
    check(32'(hz.pending_count));
    check(hz.stall_count);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    drive(1, 1, 5, 5, 5, 1, 1, 0, 0, 0);
    expect_val("reset_stall", 32'd0);
    #1;
    check(32'(hz.stall));
    regs("reset", 32'h0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();

    // RAW on a long load, cleared by its writeback
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step("raw_issue", 1'b0);
    drive(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    regs("raw_c1", 32'h20, 1);
    step("raw_c1", 1'b1);
    step("raw_c2", 1'b1);
    step("raw_c3", 1'b1);
    drive(1, 0, 0, 5, 0, 1, 0, 0, 1, 5);
    step("raw_wb", 1'b0);
    regs("raw_done", 32'h0, 0);

    // x0 is never tracked; unused sources never stall
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("x0_issue", 1'b0);
    regs("x0", 32'h0, 0);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step("x7_issue", 1'b0);
    regs("x7", 32'h80, 1);
    drive(1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    step("rs2_unused", 1'b0);
    drive(1, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    step("rs2_used", 1'b1);
    regs("x7_hold", 32'h80, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    step("x7_wb", 1'b0);
    regs("x7_done", 32'h0, 0);

    // WAW, then set and clear colliding on x9
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    step("x9_issue", 1'b0);
    regs("x9", 32'h200, 1);
    step("waw", 1'b1);
    drive(1, 1, 9, 0, 0, 0, 0, 0, 1, 9);
    step("waw_wb", 1'b0);
    regs("set_clr", 32'h200, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    step("x9_wb", 1'b0);
    regs("x9_done", 32'h0, 0);

    // Fill all pending slots
    for (int r = 1; r <= 4; r++) begin
      drive(1, 1, reg_idx_t'(r), 0, 0, 0, 0, 0, 0, 0);
      step("fill", 1'b0);
    end
    regs("filled", 32'h1E, 4);
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    step("full", 1'b1);
    drive(1, 1, 6, 0, 0, 0, 0, 0, 1, 2);
    step("full_wb", 1'b0);
    regs("full_wb", 32'h5A, 4);

    // Flush suppresses both stall and set
    drive(1, 1, 8, 0, 0, 0, 0, 1, 0, 0);
    step("flush", 1'b0);
    regs("flush", 32'h5A, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("x1_wb", 1'b0);
    regs("pre_reset", 32'h58, 3);

    // Asynchronous reset mid-flight, then a stray writeback
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    exp_sc = 0;
    expect_val("async_rst_stall", 32'd0);
    check(32'(hz.stall));
    regs("async_rst", 32'h0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    step("stray_wb", 1'b0);
    regs("stray", 32'h0, 0);
    expect_val("stray_events", 32'd1);
    check(32'(stray));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks architectural registers with an outstanding write from a long-latency unit (load, divide, multi-cycle approximate multiply).
- Sits in the decode/issue stage, directly upstream of the hazard detection and forwarding unit.
- Stalls issue when a source or destination register is busy and the value cannot yet be forwarded.
- Frees a register when its writeback arrives; from that cycle the forwarding unit supplies the data.

Parameters:
- NUM_REGS, 32, number of architectural integer registers; x0 is never tracked.
- MAX_PENDING, 4, maximum number of outstanding long-latency writes.
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode stage presents an instruction this cycle.
- issue_long  input  1  instruction writes rd through a long-latency unit.
- issue_rd  input  5  destination register index.
- rs1_index  input  5  source 1 index.
- rs2_index  input  5  source 2 index.
- rs1_used  input  1  instruction reads rs1.
- rs2_used  input  1  instruction reads rs2.
- flush  input  1  squash the instruction in decode this cycle.
- wb_valid  input  1  a long-latency result is written back this cycle.
- wb_rd  input  5  writeback register index.
- stall  output  1  hold decode/fetch this cycle (combinational).
- busy_vector  output  NUM_REGS  registered busy bits; bit 0 is always 0.
- pending_count  output  3  number of outstanding long-latency writes (0..MAX_PENDING).
- stall_count  output  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous): busy_vector=0, pending_count=0, stall_count=0. stall evaluates from the cleared state, so it is 0 during reset.
- Effective busy:
  - eff_busy[i] = busy[i] & ~(wb_valid & wb_rd==i).
  - A same-cycle writeback therefore never stalls, because the forwarding unit supplies that data.
- stall = issue_valid & ~flush & (raw | waw | full), where:
  - raw = (rs1_used & eff_busy[rs1_index]) | (rs2_used & eff_busy[rs2_index]).
  - waw = issue_long & eff_busy[issue_rd].
  - full = issue_long & (pending_count - (wb_valid ? 1 : 0)) == MAX_PENDING.
  - Index 0 never stalls.
- Accept = issue_valid & ~flush & ~stall.
- Set: on accept & issue_long & issue_rd!=0, busy[issue_rd] <= 1 at the next edge.
- Clear: on wb_valid, busy[wb_rd] <= 0. If set and clear hit the same index in the same cycle, set wins.
- Writeback to a non-busy index, or to index 0:
  - busy is unchanged and pending_count is unchanged (no underflow).
  - Verification flags this case with an assertion.
- pending_count next value = pending_count + set_event - clear_event.
  - set_event requires issue_rd!=0. An issue_long to x0 occupies no slot.
  - clear_event requires busy[wb_rd]==1.
- stall_count increments by 1 on each cycle stall=1 and saturates at all-ones.
- Latency:
  - A busy bit is visible to stall in the cycle after issue.
  - A clear takes effect combinationally in the writeback cycle and is registered at the next edge.
- flush:
  - Suppresses the set for the squashed instruction and forces stall=0.
  - Does not clear existing busy bits; already-issued operations still write back.
- Reset asserted mid-operation clears all state immediately. In-flight writebacks arriving after reset are treated as writebacks to a non-busy index.

Decomposition:
- Defines.v gains SCOREBOARD_MAX_PENDING and reuses the existing ENABLE/DISABLE constants.
- Everything else is local.
- No sub-module is needed; the per-register busy cell is a generate loop inside the block.

Test Plan:
- RAW stall then clear: issue long load to x5 (cycle 0); cycle 1 the next instruction uses rs1=x5 -> stall=1 and busy_vector[5]=1. At cycle 4 assert wb_valid, wb_rd=5 -> stall=0 in cycle 4; busy_vector=0 and pending_count=0 at cycle 5; stall_count=3.
- x0 and unused sources: issue long to x0 -> busy_vector stays 0 and pending_count stays 0. Instruction with rs2_index=7 while x7 is busy and rs2_used=0 -> stall=0.
- WAW and simultaneous set/clear:
  - x9 busy, issue long to x9 without a writeback -> stall=1.
  - Same issue with wb_rd=9 in the same cycle -> stall=0, busy[9] remains 1, pending_count unchanged.
- Full: issue 4 long ops to x1..x4, then a 5th to x6 -> stall=1. Writeback of x2 in the same cycle -> stall=0 and pending_count stays 4.
- Flush and reset:
  - flush=1 with a long issue to x8 -> stall=0 and busy[8] stays 0.
  - Assert reset asynchronously with pending_count=3 -> all outputs 0 before the next clk edge.
  - A later stray wb_rd=3 -> no underflow.
